// File: rtl/regfile_pkg.sv
// Shared constants and dump-sequencer state encoding for the 8x32 register file.
package regfile_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRead = 2'd1,
        StSend = 2'd2,
        StDone = 2'd3
    } dump_state_e;

endpackage

// File: rtl/regfile_dump.sv
// Burst read-out sequencer: walks a wrap-around address range through the register file's
// combinational read port and streams each word over a valid/ready handshake.
module regfile_dump
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] count,
    output logic [ADDR_W-1:0] rAddr,
    input  logic [DATA_W-1:0] rData,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            remain_q <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            data_q   <= data_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        data_d   = data_q;
        last_d   = last_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d   = first_addr;
                    remain_d = count;
                    state_d  = StRead;
                end
            end
            StRead: begin
                data_d  = rData;
                last_d  = (remain_q == '0);
                state_d = StSend;
            end
            StSend: begin
                if (out_ready) begin
                    if (remain_q == '0) begin
                        state_d = StDone;
                    end else begin
                        // Address wraps naturally at 2^ADDR_W.
                        addr_d   = addr_q + ADDR_W'(1);
                        remain_d = remain_q - ADDR_W'(1);
                        state_d  = StRead;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Read address comes straight from the held counter, so it only moves on a handshake.
    assign rAddr     = addr_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_valid = (state_q == StSend);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a behavioural 8x32 register file on its read port.
module tb_regfile_dump;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] rAddr;
    logic [DATA_W-1:0] rData;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;

    always #5 clk = ~clk;

    always @(posedge clk) if (we) regs[wa] <= wd;
    assign rData = regs[rAddr];

    regfile_dump u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_addr (first_addr),
        .count      (count),
        .rAddr      (rAddr),
        .rData      (rData),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [2:0]  first;
        logic [2:0]  cnt;
        int          stall_idx;
        int          stall_len;
        int          exp_n;
        logic [31:0] exp_first;
        logic [31:0] exp_lastw;
    } vec_t;

    vec_t        vecs [5];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] got_data [16];
    logic        got_last [16];
    int          got_n;
    bit          got_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; wa = a; wd = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] f, input logic [2:0] c);
        @(posedge clk); #1;
        start = 1'b1; first_addr = f; count = c;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Accepts words until done; optionally holds off word stall_idx for stall_len cycles.
    task automatic collect(input int stall_idx, input int stall_len);
        int          stall;
        logic [31:0] hd;
        logic        hl;
        stall    = 0;
        hd       = '0;
        hl       = 1'b0;
        got_n    = 0;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 100 && !got_done; cyc++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
            end else if (out_valid) begin
                if (got_n == stall_idx && stall < stall_len) begin
                    out_ready = 1'b0;
                    if (stall == 0) begin
                        hd = out_data;
                        hl = out_last;
                    end else begin
                        check("stall_data", out_data, hd);
                        check("stall_last", 32'(out_last), 32'(hl));
                    end
                    stall++;
                end else begin
                    out_ready = 1'b1;
                    if (got_n < 16) begin
                        got_data[got_n] = out_data;
                        got_last[got_n] = out_last;
                    end
                    got_n++;
                end
            end else if (stall > 0 && stall < stall_len) begin
                check("stall_valid", 32'(out_valid), 32'd1);
            end
        end
        out_ready = 1'b1;
        check("dump_done", 32'(got_done), 32'd1);
    endtask

    task automatic check_words(input string tag, input logic [2:0] f, input int n);
        check({tag, "_nwords"}, got_n, n);
        for (int k = 0; k < n && k < got_n && k < 16; k++) begin
            check({tag, "_word"}, got_data[k], 32'h1000_0000 + 32'((int'(f) + k) % 8));
            check({tag, "_last"}, 32'(got_last[k]), 32'(k == n - 1));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; first_addr = '0; count = '0;
        out_ready = 1'b1; we = 1'b0; wa = '0; wd = '0;

        vecs[0] = '{3'd6, 3'd7, -1, 0, 8, 32'h1000_0006, 32'h1000_0005};
        vecs[1] = '{3'd0, 3'd0, -1, 0, 1, 32'h1000_0000, 32'h1000_0000};
        vecs[2] = '{3'd7, 3'd1, -1, 0, 2, 32'h1000_0007, 32'h1000_0000};
        vecs[3] = '{3'd2, 3'd2,  1, 5, 3, 32'h1000_0002, 32'h1000_0004};
        vecs[4] = '{3'd4, 3'd3,  0, 2, 4, 32'h1000_0004, 32'h1000_0007};

        // Reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_last", 32'(out_last), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_data", out_data, 0);
        check("rst_raddr", 32'(rAddr), 0);

        // Single word, cycle-exact
        wr(3'd3, 32'hDEAD_BEEF);
        do_start(3'd3, 3'd0);
        @(negedge clk);
        check("sw_read_busy", 32'(busy), 1);
        check("sw_read_valid", 32'(out_valid), 0);
        check("sw_read_raddr", 32'(rAddr), 3);
        @(negedge clk);
        check("sw_valid", 32'(out_valid), 1);
        check("sw_data", out_data, 32'hDEAD_BEEF);
        check("sw_last", 32'(out_last), 1);
        @(negedge clk);
        check("sw_done", 32'(done), 1);
        check("sw_done_valid", 32'(out_valid), 0);
        @(negedge clk);
        check("sw_idle_busy", 32'(busy), 0);
        check("sw_idle_done", 32'(done), 0);

        for (int k = 0; k < 8; k++) wr(3'(k), 32'h1000_0000 + 32'(k));

        // Table-driven dumps, including wrap and backpressure
        foreach (vecs[i]) begin
            do_start(vecs[i].first, vecs[i].cnt);
            collect(vecs[i].stall_idx, vecs[i].stall_len);
            check_words("tbl", vecs[i].first, vecs[i].exp_n);
            check("tbl_first", got_data[0], vecs[i].exp_first);
            if (vecs[i].exp_n <= 16)
                check("tbl_lastw", got_data[vecs[i].exp_n - 1], vecs[i].exp_lastw);
            @(negedge clk);
            check("tbl_idle", 32'(busy), 0);
        end

        // start while busy is ignored; a later start is honoured
        do_start(3'd1, 3'd3);
        fork
            collect(-1, 0);
            begin
                repeat (3) @(posedge clk);
                #1 start = 1'b1; first_addr = 3'd6; count = 3'd0;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join
        check_words("busy_start", 3'd1, 4);
        do_start(3'd6, 3'd0);
        collect(-1, 0);
        check_words("after_busy", 3'd6, 1);

        // Reset while word 2 of 4 is presented
        do_start(3'd0, 3'd3);
        begin
            int seen;
            seen = 0;
            for (int cyc = 0; cyc < 50 && seen < 2; cyc++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("rm_reached_w2", seen, 2);
            out_ready = 1'b0;
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            check("rm_valid", 32'(out_valid), 0);
            check("rm_last", 32'(out_last), 0);
            check("rm_done", 32'(done), 0);
            check("rm_busy", 32'(busy), 0);
            check("rm_data", out_data, 0);
            check("rm_raddr", 32'(rAddr), 0);
        end
        do_start(3'd5, 3'd0);
        collect(-1, 0);
        check_words("post_rst", 3'd5, 1);

        // Write to a not-yet-read register mid-dump shows up in the stream
        do_start(3'd0, 3'd7);
        fork
            collect(-1, 0);
            begin
                bit hit;
                hit = 1'b0;
                for (int cyc = 0; cyc < 50 && !hit; cyc++) begin
                    @(negedge clk);
                    if (rAddr == 3'd2) hit = 1'b1;
                end
                we = 1'b1; wa = 3'd5; wd = 32'hCAFE_0005;
                @(posedge clk); #1;
                we = 1'b0;
            end
        join
        check("cw_nwords", got_n, 8);
        check("cw_word4", got_data[4], 32'h1000_0004);
        check("cw_word5", got_data[5], 32'hCAFE_0005);
        check("cw_word6", got_data[6], 32'h1000_0006);
        check("cw_last7", 32'(got_last[7]), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
